session_ctrl: RTL and testbench

Sequencing controller for the keypad-access machine. It owns the user session from start request through ID entry, ID check, the granted operation window and the penalty/lockout phases. It also runs the entry and operation timeouts from a single internal counter. It drives the state code and the grant/deny/lock/timeout flags consumed by the display and actuator blocks.

---
 rtl/session_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_session_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/session_ctrl.sv
// session_ctrl: session sequencer for the keypad-access machine.
// Walks a user through ID entry, the ID check, the granted operation window
// and the deny/lockout/timeout phases. One shared counter times the entry
// idle limit, the operation window and the lockout, and is cleared on every
// state change.
//
// Handshake: all inputs are single-cycle strobes with an implicit ready.
// A strobe counts only in the cycle it is high and only in the state that
// samples it: start in IDLE, keys in ENTRY, op_done in GRANT. In ENTRY,
// key_valid is accepted only while digit_cnt < ID_DIGITS, and key_enter only
// when digit_cnt == ID_DIGITS. Otherwise the strobe is dropped, with no
// backpressure and no effect on the counter.
module session_ctrl #(
   parameter int ID_DIGITS   = 4,
   parameter int DIGIT_W     = 4,
   parameter int ID_TIMEOUT  = 2**24,
   parameter int OP_TIMEOUT  = 2**25,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 2**25
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 key_valid,
   input  logic [DIGIT_W-1:0]                   key_digit,
   input  logic                                 key_clear,
   input  logic                                 key_enter,
   input  logic [ID_DIGITS*DIGIT_W-1:0]         auth_id,
   input  logic                                 op_done,
   output logic [2:0]                           state,
   output logic [ID_DIGITS*DIGIT_W-1:0]         id_buf,
   output logic [$clog2(ID_DIGITS+1)-1:0]       digit_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0]       tries_left,
   output logic                                 granted,
   output logic                                 denied,
   output logic                                 locked,
   output logic                                 timeout
);

   localparam int ID_W  = ID_DIGITS * DIGIT_W;
   localparam int DC_W  = $clog2(ID_DIGITS + 1);
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int T_MAX_A = (ID_TIMEOUT > OP_TIMEOUT) ? ID_TIMEOUT : OP_TIMEOUT;
   localparam int T_MAX   = (T_MAX_A > LOCK_CYCLES) ? T_MAX_A : LOCK_CYCLES;
   localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_GRANT   = 3'd3,
      S_DENY    = 3'd4,
      S_LOCK    = 3'd5,
      S_TIMEOUT = 3'd6
   } state_t;

   state_t           st;
   logic [CNT_W-1:0] counter;
   logic             full;

   // The state register doubles as the externally visible state code.
   assign state = st;

   // All digit slots are occupied; further digits are dropped and enter is live.
   assign full = (digit_cnt == DC_W'(ID_DIGITS));

   // Session FSM: state, shared counter, typed ID, attempt count and phase flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= S_IDLE;
         counter    <= '0;
         id_buf     <= '0;
         digit_cnt  <= '0;
         tries_left <= TRY_W'(MAX_TRIES);
         granted    <= 1'b0;
         denied     <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         case (st)
            S_IDLE: begin
               if (start) begin
                  st        <= S_ENTRY;
                  id_buf    <= '0;
                  digit_cnt <= '0;
                  counter   <= '0;
               end
            end

            S_ENTRY: begin
               if (key_clear) begin
                  id_buf    <= '0;
                  digit_cnt <= '0;
                  counter   <= '0;
               end else if (key_enter && full) begin
                  st      <= S_CHECK;
                  counter <= '0;
               end else if (key_valid && !full) begin
                  // Newest digit lands in the LS field; the oldest falls off the top.
                  id_buf    <= ID_W'({id_buf, key_digit});
                  digit_cnt <= digit_cnt + DC_W'(1);
                  counter   <= '0;
               end else if (counter == ID_LAST) begin
                  st      <= S_TIMEOUT;
                  timeout <= 1'b1;
                  counter <= '0;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end

            S_CHECK: begin
               counter <= '0;
               if (id_buf == auth_id) begin
                  st         <= S_GRANT;
                  granted    <= 1'b1;
                  tries_left <= TRY_W'(MAX_TRIES);
               end else begin
                  tries_left <= tries_left - TRY_W'(1);
                  if (tries_left == TRY_W'(1)) begin
                     st     <= S_LOCK;
                     locked <= 1'b1;
                  end else begin
                     st     <= S_DENY;
                     denied <= 1'b1;
                  end
               end
            end

            S_DENY: begin
               st        <= S_ENTRY;
               denied    <= 1'b0;
               id_buf    <= '0;
               digit_cnt <= '0;
               counter   <= '0;
            end

            S_GRANT: begin
               // op_done is checked first so it beats a coincident window expiry.
               if (op_done) begin
                  st      <= S_IDLE;
                  granted <= 1'b0;
                  counter <= '0;
               end else if (counter == OP_LAST) begin
                  st      <= S_TIMEOUT;
                  granted <= 1'b0;
                  timeout <= 1'b1;
                  counter <= '0;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end

            S_LOCK: begin
               if (counter == LOCK_LAST) begin
                  st         <= S_IDLE;
                  locked     <= 1'b0;
                  tries_left <= TRY_W'(MAX_TRIES);
                  counter    <= '0;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end

            S_TIMEOUT: begin
               st      <= S_IDLE;
               timeout <= 1'b0;
               counter <= '0;
            end

            default: begin
               st      <= S_IDLE;
               granted <= 1'b0;
               denied  <= 1'b0;
               locked  <= 1'b0;
               timeout <= 1'b0;
               counter <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_session_ctrl.sv
// tb_session_ctrl: scoreboard bench for session_ctrl. A driver applies
// directed and random strobes; a reference model built on a digit queue and
// absolute deadlines predicts the outputs after each edge, and a monitor
// compares them one edge later.
module tb_session_ctrl;

   localparam int ID_TO   = 16;
   localparam int OP_TO   = 32;
   localparam int LOCK_CY = 8;
   localparam int TRIES   = 3;
   localparam logic [15:0] AUTH = 16'h1234;

   localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_GRANT = 3;
   localparam int M_DENY = 4, M_LOCK = 5, M_TOUT = 6;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        start, key_valid, key_clear, key_enter, op_done;
   logic [3:0]  key_digit;
   logic [15:0] auth_id;
   logic [2:0]  state;
   logic [15:0] id_buf;
   logic [2:0]  digit_cnt;
   logic [1:0]  tries_left;
   logic        granted, denied, locked, timeout;

   always #5 clk = ~clk;

   session_ctrl #(
      .ID_DIGITS(4), .DIGIT_W(4), .ID_TIMEOUT(ID_TO), .OP_TIMEOUT(OP_TO),
      .MAX_TRIES(TRIES), .LOCK_CYCLES(LOCK_CY)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
      .key_digit(key_digit), .key_clear(key_clear), .key_enter(key_enter),
      .auth_id(auth_id), .op_done(op_done), .state(state), .id_buf(id_buf),
      .digit_cnt(digit_cnt), .tries_left(tries_left), .granted(granted),
      .denied(denied), .locked(locked), .timeout(timeout)
   );

   typedef logic [27:0] snap_t;
   snap_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   wire snap_t dut_snap = {state, id_buf, digit_cnt, tries_left,
                           granted, denied, locked, timeout};

   // ---------------- reference model ----------------
   int m_state;
   int digs[$];
   int tries;
   int deadline;
   int cyc;

   function automatic logic [15:0] typed_id();
      logic [15:0] v;
      v = '0;
      foreach (digs[i]) v = {v[11:0], 4'(digs[i])};
      return v;
   endfunction

   function automatic snap_t model_snap();
      return {3'(m_state), typed_id(), 3'(digs.size()), 2'(tries),
              m_state == M_GRANT, m_state == M_DENY,
              m_state == M_LOCK, m_state == M_TOUT};
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      digs.delete();
      tries = TRIES;
      deadline = 0;
   endtask

   // Predict the outcome of edge number cyc from the inputs now driven.
   task automatic model_step(input logic st, input logic kv, input logic [3:0] kd,
                             input logic kc, input logic ke, input logic od);
      case (m_state)
         M_IDLE: if (st) begin
            m_state = M_ENTRY; digs.delete(); deadline = cyc + ID_TO;
         end
         M_ENTRY: begin
            if (kc) begin
               digs.delete(); deadline = cyc + ID_TO;
            end else if (ke && digs.size() == 4) begin
               m_state = M_CHECK;
            end else if (kv && digs.size() < 4) begin
               digs.push_back(int'(kd)); deadline = cyc + ID_TO;
            end else if (cyc == deadline) begin
               m_state = M_TOUT;
            end
         end
         M_CHECK: begin
            if (typed_id() == AUTH) begin
               m_state = M_GRANT; tries = TRIES; deadline = cyc + OP_TO;
            end else begin
               tries = tries - 1;
               if (tries == 0) begin
                  m_state = M_LOCK; deadline = cyc + LOCK_CY;
               end else begin
                  m_state = M_DENY;
               end
            end
         end
         M_DENY: begin
            m_state = M_ENTRY; digs.delete(); deadline = cyc + ID_TO;
         end
         M_GRANT: begin
            if (od) m_state = M_IDLE;
            else if (cyc == deadline) m_state = M_TOUT;
         end
         M_LOCK: if (cyc == deadline) begin
            m_state = M_IDLE; tries = TRIES;
         end
         default: m_state = M_IDLE;
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic st, input logic kv, input logic [3:0] kd,
                       input logic kc, input logic ke, input logic od);
      @(negedge clk);
      start = st; key_valid = kv; key_digit = kd;
      key_clear = kc; key_enter = ke; op_done = od;
      cyc++;
      model_step(st, kv, kd, kc, ke, od);
      exp_q.push_back(model_snap());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0, 0, 0);
   endtask

   task automatic key(input logic [3:0] d);
      step(0, 1, d, 0, 0, 0);
   endtask

   task automatic type_id(input logic [15:0] v);
      for (int i = 3; i >= 0; i--) key(v[i*4 +: 4]);
   endtask

   // Reset asserted between edges; outputs must drop to reset values at once.
   task automatic async_reset(input string name);
      @(posedge clk);
      #2;
      rst = 1'b0;
      start = 0; key_valid = 0; key_clear = 0; key_enter = 0; op_done = 0;
      #1;
      model_reset();
      checks++;
      if (dut_snap !== model_snap()) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, dut_snap, model_snap());
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         snap_t e;
         e = exp_q.pop_front();
         checks++;
         if (dut_snap !== e) begin
            errors++;
            $display("FAIL snapshot cyc=%0d: got st=%0d id=%h cnt=%0d tries=%0d gdlt=%b%b%b%b expected st=%0d id=%h cnt=%0d tries=%0d gdlt=%b",
                     cyc, state, id_buf, digit_cnt, tries_left, granted, denied,
                     locked, timeout, e[27:25], e[24:9], e[8:6], e[5:4], e[3:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r;
      int p;
      logic [3:0] d;
      logic st_b, od_b;
      rst = 1'b0;
      start = 0; key_valid = 0; key_digit = 0; key_clear = 0; key_enter = 0;
      op_done = 0; auth_id = AUTH; cyc = 0;
      model_reset();
      #12;
      checks++;
      if (dut_snap !== model_snap()) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", dut_snap, model_snap());
      end
      @(negedge clk);
      rst = 1'b1;

      // Happy path
      step(1, 0, 0, 0, 0, 0);
      type_id(AUTH);
      step(0, 0, 0, 0, 1, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 1);
      idle(2);

      // Entry editing: clear, fifth digit dropped, early enter ignored
      step(1, 0, 0, 0, 0, 0);
      key(4'h1); key(4'h2);
      step(0, 0, 0, 1, 0, 0);
      type_id(AUTH); key(4'h5);
      step(0, 0, 0, 0, 1, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      key(4'h1); key(4'h2); key(4'h3);
      step(0, 0, 0, 0, 1, 0);
      idle(2);
      key(4'h4);
      step(0, 0, 0, 0, 1, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 1);

      // Lockout after three wrong IDs, then recovery
      step(1, 0, 0, 0, 0, 0);
      for (int t = 0; t < 3; t++) begin
         type_id(16'h1111);
         step(0, 0, 0, 0, 1, 0);
         idle(2);
      end
      idle(10);

      // Entry timeout, then delayed by a key at cycle 10
      step(1, 0, 0, 0, 0, 0);
      idle(20);
      step(1, 0, 0, 0, 0, 0);
      idle(9);
      key(4'h7);
      idle(20);

      // Operation timeout
      step(1, 0, 0, 0, 0, 0);
      type_id(AUTH);
      step(0, 0, 0, 0, 1, 0);
      idle(36);

      // op_done in the last window cycle beats the timeout
      step(1, 0, 0, 0, 0, 0);
      type_id(AUTH);
      step(0, 0, 0, 0, 1, 0);
      idle(32);
      step(0, 0, 0, 0, 0, 1);
      idle(3);

      // Asynchronous reset in the middle of LOCK
      step(1, 0, 0, 0, 0, 0);
      for (int t = 0; t < 3; t++) begin
         type_id(16'h1111);
         step(0, 0, 0, 0, 1, 0);
         idle(2);
      end
      idle(2);
      async_reset("reset_mid_lock");
      idle(2);

      // Randomized traffic, one key event per cycle, biased towards the right ID
      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 99);
         p = digs.size();
         if (p < 4 && $urandom_range(0, 1) == 1) d = AUTH[(3 - p)*4 +: 4];
         else d = 4'($urandom_range(0, 15));
         st_b = ($urandom_range(0, 99) < 30);
         od_b = ($urandom_range(0, 19) == 0);
         if (r < 5)       step(st_b, 0, d, 1, 0, od_b);
         else if (r < 15) step(st_b, 0, d, 0, 1, od_b);
         else if (r < 55) step(st_b, 1, d, 0, 0, od_b);
         else             step(st_b, 0, d, 0, 0, od_b);
         if ($urandom_range(0, 999) == 0) async_reset("reset_random");
      end
      idle(1);
      start = 0; key_valid = 0; key_clear = 0; key_enter = 0; op_done = 0;

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
